// File: rtl/mem_arb_pkg.sv
// Shared types and line-geometry constants for the cache-line memory arbiter.
package mem_arb_pkg;

  // Width of the byte offset inside one line of the given word count.
  function automatic int lineOffWidth(input int words);
    return $clog2(words * 4);
  endfunction

  localparam int WORDS_PER_LINE_DEF = 8;
  localparam int LINE_BYTES         = WORDS_PER_LINE_DEF * 4;
  localparam int WORD_IDX_W         = $clog2(WORDS_PER_LINE_DEF);
  localparam int LINE_OFF_W         = lineOffWidth(WORDS_PER_LINE_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } arbState_e;

endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The registered pointer names the requester that
// wins a tie; it moves to the other requester whenever a grant is accepted.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  // Grant selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
    if (accept_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  // Pointer register; reset hands the first tie to requester 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates whole-line fill and writeback bursts from the I-cache (0) and
// D-cache (1) onto a single memory data port with one-cycle read latency.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter  int ADDR_W         = 32,
  localparam int IDX_W          = $clog2(WORDS_PER_LINE),
  localparam int OFF_W          = lineOffWidth(WORDS_PER_LINE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ,
  input  logic [1:0]        WE,
  input  logic [ADDR_W-1:0] LINE_ADDR0,
  input  logic [ADDR_W-1:0] LINE_ADDR1,
  input  logic [31:0]       WDATA0,
  input  logic [31:0]       WDATA1,
  output logic [1:0]        GNT,
  output logic [IDX_W-1:0]  WIDX,
  output logic [1:0]        RVALID,
  output logic [IDX_W-1:0]  RIDX,
  output logic [31:0]       RDATA,
  output logic [1:0]        DONE,
  output logic              BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [31:0]       MEM_DIN,
  input  logic [31:0]       MEM_DOUT
);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  arbState_e         state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] lineBase_q, lineBase_d;
  logic [IDX_W-1:0]  wordIdx_q, wordIdx_d;
  logic [IDX_W-1:0]  rdIdx_q, rdIdx_d;
  logic              rdValid_q, rdValid_d;

  logic [1:0]        arbGnt;
  logic              arbAccept;
  logic              memRead;
  logic              memWrite;
  logic [1:0]        doneNow;
  logic [ADDR_W-1:0] winnerAddr;
  logic              winnerWe;
  logic [ADDR_W-1:0] wordOffset;

  rr_arb2 u_rr_arb2 (
    .clk_i    (CLK),
    .rst_i    (RST),
    .req_i    (REQ),
    .accept_i (arbAccept),
    .gnt_o    (arbGnt)
  );

  // Pick the winner's address and direction; only used when leaving IDLE.
  always_comb begin
    winnerAddr = arbGnt[1] ? LINE_ADDR1 : LINE_ADDR0;
    winnerWe   = arbGnt[1] ? WE[1] : WE[0];
    wordOffset = {{(ADDR_W-OFF_W){1'b0}}, wordIdx_q, 2'b00};
  end

  // Burst sequencing: IDLE accepts a request, READ/WRITE walk the line word by
  // word, DRAIN catches the last read word. Every burst returns through IDLE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    lineBase_d = lineBase_q;
    wordIdx_d  = wordIdx_q;
    rdIdx_d    = rdIdx_q;
    rdValid_d  = 1'b0;
    arbAccept  = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    doneNow    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          arbAccept  = 1'b1;
          gnt_d      = arbGnt;
          lineBase_d = winnerAddr & LINE_MASK;
          wordIdx_d  = '0;
          state_d    = winnerWe ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        memRead   = 1'b1;
        rdValid_d = 1'b1;
        rdIdx_d   = wordIdx_q;
        if (wordIdx_q == LAST_IDX) begin
          wordIdx_d = '0;
          state_d   = ST_DRAIN;
        end else begin
          wordIdx_d = wordIdx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        doneNow = gnt_q;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      ST_WRITE: begin
        memWrite = 1'b1;
        if (wordIdx_q == LAST_IDX) begin
          doneNow   = gnt_q;
          gnt_d     = 2'b00;
          wordIdx_d = '0;
          state_d   = ST_IDLE;
        end else begin
          wordIdx_d = wordIdx_q + IDX_W'(1);
        end
      end
      default: begin
        gnt_d     = 2'b00;
        wordIdx_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and burst bookkeeping registers; reset abandons any burst in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      lineBase_q <= '0;
      wordIdx_q  <= '0;
      rdIdx_q    <= '0;
      rdValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      lineBase_q <= lineBase_d;
      wordIdx_q  <= wordIdx_d;
      rdIdx_q    <= rdIdx_d;
      rdValid_q  <= rdValid_d;
    end
  end

  // Outputs are gated so that everything reads zero outside an active transfer.
  always_comb begin
    GNT       = gnt_q;
    WIDX      = wordIdx_q;
    RVALID    = rdValid_q ? gnt_q : 2'b00;
    RIDX      = rdValid_q ? rdIdx_q : '0;
    RDATA     = rdValid_q ? MEM_DOUT : 32'h0;
    DONE      = doneNow;
    BUSY      = (state_q != ST_IDLE);
    MEM_READ  = memRead;
    MEM_WRITE = memWrite;
    MEM_ADDR  = (memRead || memWrite) ? (lineBase_q | wordOffset) : '0;
    MEM_DIN   = memWrite ? (gnt_q[1] ? WDATA1 : WDATA0) : 32'h0;
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: a cycle table for one fill and one writeback,
// then hand-written round-robin, abort-by-reset and ignored-change sequences.
module tb_mem_line_arbiter;

  localparam int N      = 8;
  localparam int ADDR_W = 32;

  logic              CLK;
  logic              RST;
  logic [1:0]        REQ;
  logic [1:0]        WE;
  logic [ADDR_W-1:0] LINE_ADDR0;
  logic [ADDR_W-1:0] LINE_ADDR1;
  logic [31:0]       WDATA0;
  logic [31:0]       WDATA1;
  logic [1:0]        GNT;
  logic [2:0]        WIDX;
  logic [1:0]        RVALID;
  logic [2:0]        RIDX;
  logic [31:0]       RDATA;
  logic [1:0]        DONE;
  logic              BUSY;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [31:0]       MEM_DIN;
  logic [31:0]       MEM_DOUT;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [0:4095];
  logic        written [0:4095];

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  gnt;
    logic        busy;
    logic        memRd;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic [1:0]  rvalid;
    logic [2:0]  ridx;
    logic [31:0] rdata;
    logic [1:0]  done;
    logic [2:0]  widx;
  } vec_t;

  vec_t vecs[$];

  mem_line_arbiter #(.WORDS_PER_LINE(N), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .WE         (WE),
    .LINE_ADDR0 (LINE_ADDR0),
    .LINE_ADDR1 (LINE_ADDR1),
    .WDATA0     (WDATA0),
    .WDATA1     (WDATA1),
    .GNT        (GNT),
    .WIDX       (WIDX),
    .RVALID     (RVALID),
    .RIDX       (RIDX),
    .RDATA      (RDATA),
    .DONE       (DONE),
    .BUSY       (BUSY),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .MEM_DIN    (MEM_DIN),
    .MEM_DOUT   (MEM_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Requesters supply writeback data combinationally from the word index.
  assign WDATA0 = 32'h50 + {29'b0, WIDX};
  assign WDATA1 = 32'hA0 + {29'b0, WIDX};

  function automatic logic [31:0] defWord(input int w);
    return 32'hD000_0000 | 32'(w);
  endfunction

  // Memory model: never-written words read back as a fixed pattern.
  always @(posedge CLK) begin
    if (MEM_READ) begin
      MEM_DOUT <= written[MEM_ADDR[13:2]] ? mem[MEM_ADDR[13:2]] : defWord(int'(MEM_ADDR[13:2]));
    end
    if (MEM_WRITE) begin
      mem[MEM_ADDR[13:2]]     <= MEM_DIN;
      written[MEM_ADDR[13:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] memWord(input int w);
    return written[w] ? mem[w] : defWord(w);
  endfunction

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                               input logic [31:0] a0, input logic [31:0] a1);
    REQ        = req;
    WE         = we;
    LINE_ADDR0 = a0;
    LINE_ADDR1 = a1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " GNT"},       32'(GNT), 32'h0);
    checkOutput({tag, " BUSY"},      32'(BUSY), 32'h0);
    checkOutput({tag, " MEM_READ"},  32'(MEM_READ), 32'h0);
    checkOutput({tag, " MEM_WRITE"}, 32'(MEM_WRITE), 32'h0);
    checkOutput({tag, " MEM_ADDR"},  MEM_ADDR, 32'h0);
    checkOutput({tag, " MEM_DIN"},   MEM_DIN, 32'h0);
    checkOutput({tag, " DONE"},      32'(DONE), 32'h0);
    checkOutput({tag, " RVALID"},    32'(RVALID), 32'h0);
    checkOutput({tag, " WIDX"},      32'(WIDX), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    logic [1:0] grants [3];
    int         gaps   [3];
    int         nGrant;
    int         idleRun;
    logic [1:0] prevGnt;
    logic       doneSeen;
    logic [1:0] expGrant [3];

    for (int i = 0; i < 4096; i++) written[i] = 1'b0;
    MEM_DOUT = 32'h0;
    RST = 1'b1;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checkAllZero("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Fill, requester 0, unaligned address 0x104
    for (int c = 0; c <= 10; c++) begin
      v = '0;
      v.req   = (c <= 9) ? 2'b01 : 2'b00;
      v.addr0 = 32'h104;
      if (c >= 1 && c <= 8) begin
        v.gnt     = 2'b01;
        v.busy    = 1'b1;
        v.memRd   = 1'b1;
        v.memAddr = 32'h100 + 32'(4 * (c - 1));
        v.widx    = 3'(c - 1);
      end
      if (c >= 2 && c <= 9) begin
        v.rvalid = 2'b01;
        v.ridx   = 3'(c - 2);
        v.rdata  = defWord(32'h40 + c - 2);
      end
      if (c == 9) begin
        v.gnt  = 2'b01;
        v.busy = 1'b1;
        v.done = 2'b01;
      end
      vecs.push_back(v);
    end

    // Writeback, requester 1, 0x2000
    for (int c = 0; c <= 9; c++) begin
      v = '0;
      v.req   = (c <= 8) ? 2'b10 : 2'b00;
      v.we    = (c <= 8) ? 2'b10 : 2'b00;
      v.addr1 = 32'h2000;
      if (c >= 1 && c <= 8) begin
        v.gnt     = 2'b10;
        v.busy    = 1'b1;
        v.memWr   = 1'b1;
        v.memAddr = 32'h2000 + 32'(4 * (c - 1));
        v.memDin  = 32'hA0 + 32'(c - 1);
        v.widx    = 3'(c - 1);
      end
      if (c == 8) v.done = 2'b10;
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr0, vecs[i].addr1);
      #1;
      checkOutput($sformatf("v%0d GNT", i),       32'(GNT), 32'(vecs[i].gnt));
      checkOutput($sformatf("v%0d BUSY", i),      32'(BUSY), 32'(vecs[i].busy));
      checkOutput($sformatf("v%0d MEM_READ", i),  32'(MEM_READ), 32'(vecs[i].memRd));
      checkOutput($sformatf("v%0d MEM_WRITE", i), 32'(MEM_WRITE), 32'(vecs[i].memWr));
      checkOutput($sformatf("v%0d MEM_ADDR", i),  MEM_ADDR, vecs[i].memAddr);
      checkOutput($sformatf("v%0d WIDX", i),      32'(WIDX), 32'(vecs[i].widx));
      checkOutput($sformatf("v%0d RVALID", i),    32'(RVALID), 32'(vecs[i].rvalid));
      checkOutput($sformatf("v%0d DONE", i),      32'(DONE), 32'(vecs[i].done));
      if (vecs[i].memWr) begin
        checkOutput($sformatf("v%0d MEM_DIN", i), MEM_DIN, vecs[i].memDin);
      end
      if (vecs[i].rvalid != 2'b00) begin
        checkOutput($sformatf("v%0d RIDX", i),  32'(RIDX), 32'(vecs[i].ridx));
        checkOutput($sformatf("v%0d RDATA", i), RDATA, vecs[i].rdata);
      end
      @(negedge CLK);
    end

    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("wb mem word %0d", k), memWord(32'h800 + k), 32'hA0 + 32'(k));
    end

    // Round-robin with both requesting from reset
    RST = 1'b1;
    #1;
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(2'b11, 2'b00, 32'h0, 32'h40);
    nGrant  = 0;
    idleRun = 0;
    prevGnt = 2'b00;
    for (int cyc = 0; cyc < 80 && nGrant < 3; cyc++) begin
      #1;
      checkOutput("gnt two-hot", 32'(GNT == 2'b11), 32'h0);
      checkOutput("strobes both high", 32'(MEM_READ && MEM_WRITE), 32'h0);
      if (GNT != 2'b00 && prevGnt == 2'b00) begin
        grants[nGrant] = GNT;
        gaps[nGrant]   = idleRun;
        nGrant++;
      end
      if (GNT == 2'b00) idleRun++;
      else idleRun = 0;
      prevGnt = GNT;
      @(negedge CLK);
    end
    checkOutput("rr grants seen", 32'(nGrant), 32'd3);
    expGrant[0] = 2'b01;
    expGrant[1] = 2'b10;
    expGrant[2] = 2'b01;
    for (int i = 0; i < nGrant; i++) begin
      checkOutput($sformatf("rr grant %0d", i), 32'(grants[i]), 32'(expGrant[i]));
      if (i > 0) checkOutput($sformatf("rr gap %0d", i), 32'(gaps[i]), 32'd1);
    end
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 20 && BUSY; i++) @(negedge CLK);
    #1;
    checkOutput("rr back to idle", 32'(BUSY), 32'h0);
    @(negedge CLK);

    // Reset in the fifth cycle of a writeback
    doneSeen = 1'b0;
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h3000);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (DONE != 2'b00) doneSeen = 1'b1;
      @(negedge CLK);
    end
    #1;
    checkOutput("abort c4 MEM_WRITE", 32'(MEM_WRITE), 32'h1);
    checkOutput("abort c4 WIDX", 32'(WIDX), 32'd3);
    RST = 1'b1;
    #1;
    checkAllZero("async reset");
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      #1;
      if (DONE != 2'b00) doneSeen = 1'b1;
    end
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort no DONE", 32'(doneSeen), 32'h0);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("abort mem word %0d", k), memWord(32'hC00 + k),
                  (k < 3) ? 32'hA0 + 32'(k) : defWord(32'hC00 + k));
    end

    // Address change and REQ drop mid-fill are ignored
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) applyStimulus(2'b01, 2'b00, 32'h400, 32'h0);
      if (c == 3) applyStimulus(2'b00, 2'b00, 32'h7F0, 32'h0);
      #1;
      if (c >= 1 && c <= 8) begin
        checkOutput($sformatf("hold c%0d MEM_ADDR", c), MEM_ADDR, 32'h400 + 32'(4 * (c - 1)));
        checkOutput($sformatf("hold c%0d MEM_READ", c), 32'(MEM_READ), 32'h1);
      end
      if (c >= 2 && c <= 9) begin
        checkOutput($sformatf("hold c%0d RVALID", c), 32'(RVALID), 32'h1);
        checkOutput($sformatf("hold c%0d RIDX", c), 32'(RIDX), 32'(c - 2));
        checkOutput($sformatf("hold c%0d RDATA", c), RDATA, defWord(32'h100 + c - 2));
      end
      if (c == 9) checkOutput("hold DONE", 32'(DONE), 32'h1);
      if (c == 10) checkOutput("hold idle after", 32'(BUSY), 32'h0);
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
MEM_LINE_ARBITER -- requirements
Module: mem_line_arbiter

Interface
REQ-001 Parameter WORDS_PER_LINE, default 8, words per cache line (power of 2, >=2).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Ports: one clock; reset is asynchronous and active-high. Ports are CLK and RST.
REQ-004 CLK  in  1  system clock, all state on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 REQ  in  2  line-transfer request; bit 0 = I-cache, bit 1 = D-cache.
REQ-007 WE  in  2  per-requester: 1 = line writeback, 0 = line fill; sampled with REQ.
REQ-008 LINE_ADDR0 / LINE_ADDR1  in  ADDR_W  line base byte address per requester.
REQ-009 WDATA0 / WDATA1  in  32  writeback word for the current WIDX, driven combinationally by the requester.
REQ-010 GNT  out  2  one-hot grant, held for the whole burst.
REQ-011 WIDX  out  log2(WORDS_PER_LINE)  word index currently issued to memory.
REQ-012 RVALID  out  2  read word valid, routed to the granted requester.
REQ-013 RIDX  out  log2(WORDS_PER_LINE)  index of the word on RDATA.
REQ-014 RDATA  out  32  fill word; equals MEM_DOUT.
REQ-015 DONE  out  2  one-cycle burst-complete pulse to the granted requester.
REQ-016 BUSY  out  1  high in any state other than IDLE.
REQ-017 MEM_ADDR  out  ADDR_W  memory data-port address.
REQ-018 MEM_READ / MEM_WRITE  out  1  memory data-port strobes.
REQ-019 MEM_DIN  out  32  memory write data.
REQ-020 MEM_DOUT  in  32  memory read data, valid one cycle after MEM_READ.

Function
REQ-021 FSM states are IDLE, READ, DRAIN and WRITE.
REQ-022 IDLE: if any REQ bit is high, the arbiter SHALL register the grant, latch LINE_ADDR and WE of the winner, and enter READ (WE=0) or WRITE (WE=1) next cycle with GNT asserted.
REQ-023 Arbitration is round-robin: when both requesters request, the one not granted last wins; the pointer resets to favour requester 0.
REQ-024 The low log2(WORDS_PER_LINE*4) bits of the latched address SHALL be forced to zero.
REQ-025 MEM_ADDR = base + 4*WIDX while READ or WRITE; outside those states MEM_ADDR = 0.
REQ-026 READ: for k=0..N-1 on consecutive cycles, WIDX=k, MEM_READ=1; after k=N-1 go to DRAIN.
REQ-027 In the cycle after each READ issue of word k: RVALID[g]=1, RIDX=k, RDATA=MEM_DOUT.
REQ-028 DRAIN lasts one cycle: delivers word N-1, pulses DONE[g], then goes to IDLE.
REQ-029 WRITE: for k=0..N-1, WIDX=k, MEM_WRITE=1, MEM_DIN=WDATA of the granted requester.
REQ-030 WRITE: DONE[g] pulses in the k=N-1 cycle, then the FSM goes to IDLE.
REQ-031 Fill timing: REQ at cycle 0 gives GNT at cycle 1, first RVALID at cycle 2, DONE at cycle N+1.
REQ-032 The FSM always returns to IDLE between bursts, giving a one-cycle minimum gap; no back-to-back chaining.
REQ-033 REQ or LINE_ADDR changes after grant SHALL be ignored until IDLE; the burst always completes.
REQ-034 Requesters SHALL keep REQ high until DONE; REQ still high in the cycle after DONE is a new request.
REQ-035 MEM_READ and MEM_WRITE are never high simultaneously; GNT is never two-hot.
REQ-036 The WIDX counter wraps only at FSM exit; no partial or wrapping bursts.

Reset
REQ-037 RST asynchronously forces IDLE, RR pointer=0, and all outputs to 0, including MEM_READ, MEM_WRITE, GNT, DONE and RVALID.
REQ-038 Reset mid-burst aborts the burst; a partially written line is left as is; no DONE is issued.

Structure
REQ-039 Package mem_arb_pkg holds the state enum, WORDS_PER_LINE default, LINE_BYTES and index-width constants.
REQ-040 One sub-module, rr_arb2: 2-way round-robin grant with a registered last-winner pointer.

Verification
REQ-041 REQ=01, WE=0, LINE_ADDR0=0x104 -> GNT=01 at c1, MEM_ADDR 0x100..0x11C at c1..c8, RVALID at c2..c9 with RIDX 0..7, DONE[0] at c9.
REQ-042 REQ=10, WE=1, LINE_ADDR1=0x2000, WDATA1=0xA0+WIDX -> MEM_WRITE at c1..c8, memory words 0x2000..0x201C = 0xA0..0xA7, DONE[1] at c8.
REQ-043 REQ=11 held after reset -> grants alternate 01, 10, 01, each separated by one IDLE cycle.
REQ-044 RST asserted at c4 of a writeback -> all outputs 0 asynchronously; words 3..7 not written; no DONE.
REQ-045 LINE_ADDR0 changed and REQ0 dropped at c3 of a fill -> burst completes at the original addresses and DONE still pulses.
